i2c_target_regs: RTL and testbench

I2C responder (target) modelling a register-mapped video transmitter on the same bus as the config master. It answers writes and reads at CHIP_ADDR and holds an internal byte register file. It exposes a write-strobe side channel and a live status byte, so it can serve as the on-board bus partner and as the bench model for master-side controllers.

---
 rtl/i2c_target_regs_if.sv | 8 +
 rtl/i2c_target_regs.sv | 132 +++++++++++++
 tb/tb_i2c_target_regs.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: open-drain I2C bus (scl driven by the master, sda wired-AND with pull-up)
interface i2c_target_regs_if;
    logic scl;
    wire  sda;
    pullup (sda);
    modport master (output scl, inout sda);
    modport slave  (input scl, inout sda);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte register file, write-strobe side channel and live status byte
module i2c_target_regs #(
    parameter logic [6:0] CHIP_ADDR   = 7'h38,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] STATUS_ADDR = 8'h09,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    i2c_target_regs_if.slave bus,
    input  logic [7:0]       status_in,
    output logic             wr_strobe,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
    } state_t;
    state_t state, nxt;
    logic [1:0] scl_s, sda_s;
    logic scl_d, sda_d, oe, rw, acked;
    logic [2:0] cnt;
    logic [7:0] sh, ptr, rd_byte, byte_in;
    logic [7:0] regs [2**ADDR_W];
    logic rise, fall, start, stop, last, in_rng;

    assign bus.sda = oe ? 1'b0 : 1'bz;
    assign rise    = scl_s[1] & ~scl_d;
    assign fall    = ~scl_s[1] & scl_d;
    assign start   = scl_s[1] & scl_d & sda_d & ~sda_s[1];
    assign stop    = scl_s[1] & scl_d & ~sda_d & sda_s[1];
    assign last    = rise & (cnt == 3'd7);
    assign byte_in = {sh[6:0], sda_s[1]};
    assign in_rng  = (ptr >> ADDR_W) == 8'd0;
    assign rd_byte = ptr == STATUS_ADDR ? status_in : in_rng ? regs[ptr[ADDR_W-1:0]] : 8'h00;

    // protocol state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nxt;
    end

    // next state: START/STOP override everything, otherwise advance on bit and ACK boundaries
    always_comb begin
        nxt = state;
        if (start) nxt = ADDR;
        else if (stop) nxt = IDLE;
        else case (state)
            ADDR:                 if (last) nxt = byte_in[7:1] == CHIP_ADDR ? ADDR_ACK : IGNORE;
            ADDR_ACK:             if (fall && oe) nxt = rw ? RDATA : REG;
            REG:                  if (last) nxt = REG_ACK;
            REG_ACK, WDATA_ACK:   if (fall && oe) nxt = WDATA;
            WDATA:                if (last) nxt = WDATA_ACK;
            RDATA:                if (last) nxt = MACK;
            MACK:                 if (rise && sda_s[1]) nxt = IGNORE;
                                  else if (fall && acked) nxt = RDATA;
            default:              ;
        endcase
    end

    // synchronisers, shifting, ACK/read-bit drive, pointer, register file and write strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s     <= 2'b11;
            sda_s     <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            oe        <= 1'b0;
            rw        <= 1'b0;
            acked     <= 1'b0;
            cnt       <= 3'd0;
            sh        <= 8'h00;
            ptr       <= 8'h00;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= RESET_VAL;
        end else begin
            scl_s     <= {scl_s[0], bus.scl};
            sda_s     <= {sda_s[0], bus.sda};
            scl_d     <= scl_s[1];
            sda_d     <= sda_s[1];
            wr_strobe <= 1'b0;
            if (start || stop) begin
                oe    <= 1'b0;
                cnt   <= 3'd0;
                acked <= 1'b0;
                if (stop) busy <= 1'b0;
            end else begin
                if (rise && state inside {ADDR, REG, WDATA, RDATA}) cnt <= cnt + 3'd1;
                if (rise && state inside {ADDR, REG, WDATA}) sh <= byte_in;
                case (state)
                    ADDR: if (last) begin
                        rw <= byte_in[0];
                        if (byte_in[7:1] == CHIP_ADDR) busy <= 1'b1;
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: if (fall) begin
                        if (!oe) oe <= 1'b1;
                        else if (state == ADDR_ACK && rw) begin
                            sh  <= {rd_byte[6:0], 1'b0};
                            oe  <= ~rd_byte[7];
                            ptr <= ptr + 8'd1;
                        end else oe <= 1'b0;
                    end
                    REG: if (last) ptr <= byte_in;
                    WDATA: if (last) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= byte_in;
                        if (in_rng && ptr != STATUS_ADDR) regs[ptr[ADDR_W-1:0]] <= byte_in;
                        ptr       <= ptr + 8'd1;
                    end
                    RDATA: if (fall) begin
                        oe <= ~sh[7];
                        sh <= {sh[6:0], 1'b0};
                    end
                    MACK: if (fall) begin
                        if (acked) begin
                            sh    <= {rd_byte[6:0], 1'b0};
                            oe    <= ~rd_byte[7];
                            ptr   <= ptr + 8'd1;
                            acked <= 1'b0;
                        end else oe <= 1'b0;
                    end else if (rise && !sda_s[1]) acked <= 1'b1;
                    default: oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-level I2C master driving the target, checked against constants and a byte-array model
module tb_i2c_target_regs;
    logic clk = 1'b0, reset = 1'b0, m_low = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic wr_strobe, busy;
    logic [7:0] wr_addr, wr_data;
    int n_chk = 0, n_fail = 0;
    logic busy_seen = 1'b0, low_seen = 1'b0;
    logic [15:0] sq[$];
    logic [7:0] wbuf[4], rbuf[4], mem[256], mptr;
    typedef struct {logic [7:0] ptr; logic [7:0] data; logic [7:0] exp;} vec_t;
    vec_t vt[7];

    i2c_target_regs_if bus();
    assign bus.sda = m_low ? 1'b0 : 1'bz;

    i2c_target_regs dut (
        .clk(clk), .reset(reset), .bus(bus), .status_in(status_in),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // monitor: log strobes, note busy and any target-driven low, sampled 2 ns after each edge
    always @(posedge clk) begin
        #2;
        if (wr_strobe) sq.push_back({wr_addr, wr_data});
        if (busy) busy_seen = 1'b1;
        if (!m_low && bus.sda === 1'b0) low_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b, output logic s);
        m_low = ~b; tick(5);
        bus.scl = 1'b1; tick(5);
        s = bus.sda; tick(5);
        bus.scl = 1'b0; tick(5);
    endtask

    task automatic do_start();
        if (!bus.scl) begin
            m_low = 1'b0; tick(5);
            bus.scl = 1'b1; tick(5);
        end
        m_low = 1'b1; tick(5);
        bus.scl = 1'b0; tick(5);
    endtask

    task automatic do_stop(input logic tb);
        m_low = 1'b1; tick(5);
        bus.scl = 1'b1; tick(5);
        m_low = 1'b0;
        if (tb) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("stop_busy_2clk", busy, 1);
            @(posedge clk); #1;
            chk("stop_busy_3clk", busy, 0);
        end
        tick(10);
    endtask

    task automatic send(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], s);
        put_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            b[i] = s;
        end
        put_bit(~ack, s);
    endtask

    task automatic wr(input logic [7:0] p, input int n, input logic tb, input string tag);
        logic a;
        sq.delete();
        do_start();
        send(8'h70, a); chk({tag, "_addr_ack"}, a, 1);
        send(p, a);     chk({tag, "_ptr_ack"}, a, 1);
        for (int i = 0; i < n; i++) begin
            send(wbuf[i], a);
            chk({tag, "_data_ack"}, a, 1);
        end
        if (tb) chk({tag, "_busy_mid"}, busy, 1);
        do_stop(tb);
        chk({tag, "_strobes"}, 16'(sq.size()), 16'(n));
        for (int i = 0; i < n && i < sq.size(); i++)
            chk({tag, "_strobe"}, sq[i], {p + 8'(i), wbuf[i]});
    endtask

    task automatic rd(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
        logic a;
        do_start();
        if (set_ptr) begin
            send(8'h70, a); chk({tag, "_waddr_ack"}, a, 1);
            send(p, a);     chk({tag, "_ptr_ack"}, a, 1);
            do_start();
        end
        send(8'h71, a); chk({tag, "_raddr_ack"}, a, 1);
        for (int i = 0; i < n; i++) recv(i < n - 1, rbuf[i]);
        chk({tag, "_sda_released"}, bus.sda, 1);
        do_stop(1'b0);
    endtask

    initial begin
        logic a, s;
        int kind, n;
        logic [7:0] p, e;
        vt[0] = '{8'h00, 8'h11, 8'h11};
        vt[1] = '{8'h0F, 8'hA5, 8'hA5};
        vt[2] = '{8'h09, 8'h77, 8'h5A};
        vt[3] = '{8'h10, 8'h33, 8'h00};
        vt[4] = '{8'hFF, 8'h44, 8'h00};
        vt[5] = '{8'h07, 8'h00, 8'h00};
        vt[6] = '{8'h08, 8'hFF, 8'hFF};
        bus.scl = 1'b1;
        tick(4);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_sda", bus.sda, 1);
        reset = 1'b1;
        tick(5);

        wbuf[0] = 8'hFF;
        wr(8'h08, 1, 1'b1, "t1");
        rd(1'b1, 8'h08, 1, "t1_rb"); chk("t1_rb_val", rbuf[0], 8'hFF);

        wbuf[0] = 8'hFE; wbuf[1] = 8'h00; wbuf[2] = 8'h80;
        wr(8'h08, 3, 1'b0, "burst");
        status_in = 8'h3C;
        rd(1'b1, 8'h08, 3, "burst_rb");
        chk("burst_rb0", rbuf[0], 8'hFE);
        chk("burst_rb1", rbuf[1], 8'h3C);
        chk("burst_rb2", rbuf[2], 8'h80);

        status_in = 8'h06;
        rd(1'b1, 8'h09, 1, "stat"); chk("stat_val", rbuf[0], 8'h06);

        wbuf[0] = 8'hC3;
        wr(8'h0F, 1, 1'b0, "wrap_w");
        rd(1'b1, 8'h0F, 3, "wrap");
        chk("wrap0", rbuf[0], 8'hC3);
        chk("wrap1", rbuf[1], 8'h00);
        chk("wrap2", rbuf[2], 8'h00);

        sq.delete(); busy_seen = 1'b0; low_seen = 1'b0;
        do_start();
        send(8'hA0, a); chk("mis_addr_ack", a, 0);
        send(8'h08, a); chk("mis_ptr_ack", a, 0);
        send(8'h55, a); chk("mis_data_ack", a, 0);
        do_stop(1'b0);
        chk("mis_strobes", 16'(sq.size()), 0);
        chk("mis_busy", busy_seen, 0);
        chk("mis_sda_low", low_seen, 0);

        status_in = 8'h5A;
        for (int v = 0; v < 7; v++) begin
            wbuf[0] = vt[v].data;
            wr(vt[v].ptr, 1, 1'b0, "vec");
            rd(1'b1, vt[v].ptr, 1, "vec_rb");
            chk("vec_val", rbuf[0], vt[v].exp);
        end

        status_in = 8'h00;
        do_start();
        send(8'h70, a); send(8'h10, a);
        do_start();
        send(8'h71, a); chk("ab_ack", a, 1);
        for (int i = 0; i < 3; i++) put_bit(1'b1, s);
        chk("ab_drive", bus.sda, 0);
        reset = 1'b0; #1;
        chk("ab_release", bus.sda, 1);
        chk("ab_busy", busy, 0);
        tick(3); bus.scl = 1'b1; tick(3); reset = 1'b1; tick(10);
        wbuf[0] = 8'hFF;
        wr(8'h08, 1, 1'b1, "ab_wr");
        rd(1'b1, 8'h08, 1, "ab_rb8"); chk("ab_rb8_val", rbuf[0], 8'hFF);
        rd(1'b1, 8'h00, 1, "ab_rb0"); chk("ab_rb0_val", rbuf[0], 8'h00);

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8] = 8'hFF;
        mptr = 8'h01;
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 4);
            n = $urandom_range(1, 3);
            p = ($urandom_range(0, 4) == 0) ? 8'hFE : 8'($urandom_range(0, 31));
            status_in = 8'($urandom);
            if (kind <= 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                wr(p, n, 1'b0, "rnd_wr");
                for (int i = 0; i < n; i++) begin
                    if (p < 8'd16 && p != 8'h09) mem[p] = wbuf[i];
                    p = p + 8'd1;
                end
                mptr = p;
            end else begin
                if (kind == 4) p = mptr;
                rd(kind != 4, p, n, "rnd_rd");
                for (int i = 0; i < n; i++) begin
                    e = (p == 8'h09) ? status_in : mem[p];
                    chk("rnd_rd_val", rbuf[i], e);
                    p = p + 8'd1;
                end
                mptr = p;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
